multi_voice_phase_accumulator: RTL

//  Time-multiplexed phase accumulator for the oscillator path: holds one PHASE_W-bit phase and one tuning

---
 rtl/synth_osc_pkg.sv | 6 +
 rtl/phase_add_carry.sv | 12 +
 rtl/multi_voice_phase_accumulator.sv | 101 ++++++++++
 3 files changed

// File: rtl/synth_osc_pkg.sv
// synth_osc_pkg: shared constants and sweep state type for the oscillator phase path
package synth_osc_pkg;
    localparam int PHASE_W_DEF = 19;
    localparam int VOICES_DEF  = 8;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/phase_add_carry.sv
// phase_add_carry: combinational W-bit adder with carry in and carry out
module phase_add_carry #(
    parameter int W = 19
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] sum_o,
    output logic         c_o
);
    assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};
endmodule

// File: rtl/multi_voice_phase_accumulator.sv
// multi_voice_phase_accumulator: time-multiplexed per-voice phase accumulator sharing one adder
module multi_voice_phase_accumulator
    import synth_osc_pkg::*;
#(
    parameter  int PHASE_W = PHASE_W_DEF,
    parameter  int VOICES  = VOICES_DEF,
    localparam int VOICE_W = $clog2(VOICES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_tick,
    input  logic               tw_we,
    input  logic [VOICE_W-1:0] tw_addr,
    input  logic [PHASE_W-1:0] tw_data,
    input  logic [VOICES-1:0]  phase_clr,
    output logic               busy,
    output logic               out_valid,
    output logic [VOICE_W-1:0] out_voice,
    output logic [PHASE_W-1:0] out_phase,
    output logic               out_wrap,
    output logic               sweep_done,
    output logic               overrun
);
    state_t               state_q, state_d;
    logic [VOICE_W-1:0]   v_q, v_d;
    logic [PHASE_W-1:0]   phase_q [VOICES];
    logic [PHASE_W-1:0]   inc_q [VOICES];
    logic [VOICES-1:0]    pend_q, pend_d, hit;
    logic [PHASE_W-1:0]   sum, new_phase;
    logic                 carry, run, last, clr_v;
    logic                 out_valid_q, out_wrap_q, sweep_done_q, overrun_q;
    logic [VOICE_W-1:0]   out_voice_q;
    logic [PHASE_W-1:0]   out_phase_q;

    phase_add_carry #(.W(PHASE_W)) u_add (
        .a_i  (phase_q[v_q]),
        .b_i  (inc_q[v_q]),
        .c_i  (1'b0),
        .sum_o(sum),
        .c_o  (carry)
    );

    assign run  = state_q == RUN;
    assign last = v_q == VOICE_W'(VOICES - 1);
    assign busy = run;

    // sweep sequencing, hard-sync resolution and pending-mask update
    always_comb begin
        state_d   = run ? (last ? IDLE : RUN) : (sample_tick ? RUN : IDLE);
        v_d       = run ? v_q + 1'b1 : '0;
        clr_v     = run && pend_q[v_q];
        new_phase = clr_v ? '0 : sum;
        hit       = run ? (VOICES'(1) << v_q) : '0;
        pend_d    = (pend_q & ~hit) | phase_clr;
    end

    // control state and registered result stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            v_q          <= '0;
            pend_q       <= '0;
            out_valid_q  <= 1'b0;
            out_voice_q  <= '0;
            out_phase_q  <= '0;
            out_wrap_q   <= 1'b0;
            sweep_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            v_q          <= v_d;
            pend_q       <= pend_d;
            out_valid_q  <= run;
            out_voice_q  <= run ? v_q : '0;
            out_phase_q  <= run ? new_phase : '0;
            out_wrap_q   <= run && !clr_v && carry;
            sweep_done_q <= run && last;
            overrun_q    <= run && sample_tick;
        end
    end

    // per-voice phase and tuning-word storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VOICES; i++) begin
                phase_q[i] <= '0;
                inc_q[i]   <= '0;
            end
        end else begin
            if (run) phase_q[v_q] <= new_phase;
            if (tw_we) inc_q[tw_addr] <= tw_data;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_voice  = out_voice_q;
    assign out_phase  = out_phase_q;
    assign out_wrap   = out_wrap_q;
    assign sweep_done = sweep_done_q;
    assign overrun    = overrun_q;
endmodule
